// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the five-client SDRAM arbiter.
// Client indices follow the audio datapath order used at the top-level port vectors.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CLI_LOAD   = 0;
  localparam int CLI_MIX    = 1;
  localparam int CLI_PITCH  = 2;
  localparam int CLI_RECORD = 3;
  localparam int CLI_PLAY   = 4;

  // Samples live in the low half of each 32-bit SDRAM word.
  localparam logic [3:0] BE_LOW16_N = 4'b1100;
  localparam logic [3:0] BE_NONE_N  = 4'b1111;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
// Assumes ptr < N.
module rr_select #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    // Scan from the farthest offset down so the nearest request to ptr overwrites last.
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        found = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter serialising five 16-bit audio clients onto one Avalon-MM SDRAM slave.
// One transaction at a time; each completes with a one-cycle one-hot done pulse to its owner.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_CLIENTS  = 5,
  parameter int ADDR_W     = 23,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_CLIENTS-1:0]        i_req,
  input  logic [N_CLIENTS-1:0]        i_we,
  input  logic [N_CLIENTS*ADDR_W-1:0] i_addr,
  input  logic [N_CLIENTS*16-1:0]     i_wdata,
  output logic [15:0]                 o_rdata,
  output logic [N_CLIENTS-1:0]        o_done,
  output logic [2:0]                  o_grant_id,
  output logic                        o_busy,
  output logic                        o_rd_timeout,
  output logic [ADDR_W-1:0]           o_sdram_address,
  output logic [3:0]                  o_sdram_byteenable_n,
  output logic                        o_sdram_chipselect,
  output logic [31:0]                 o_sdram_writedata,
  output logic                        o_sdram_read_n,
  output logic                        o_sdram_write_n,
  input  logic [31:0]                 i_sdram_readdata,
  input  logic                        i_sdram_readdatavalid,
  input  logic                        i_sdram_waitrequest
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic              cur_we;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  rd_cnt_nxt;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  ptr_after_pick;

  logic [ADDR_W-1:0] addr_arr  [N_CLIENTS];
  logic [15:0]       wdata_arr [N_CLIENTS];

  // Upper half of the SDRAM word carries no sample data.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^i_sdram_readdata[31:16];

  always_comb begin
    for (int k = 0; k < N_CLIENTS; k++) begin
      addr_arr[k]  = i_addr[k*ADDR_W +: ADDR_W];
      wdata_arr[k] = i_wdata[k*16 +: 16];
    end
  end

  rr_select #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req   (i_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign ptr_after_pick = (pick_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
  assign rd_cnt_nxt     = rd_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      cur_we               <= 1'b0;
      rd_cnt               <= '0;
      o_done               <= '0;
      o_rdata              <= '0;
      o_grant_id           <= '0;
      o_busy               <= 1'b0;
      o_rd_timeout         <= 1'b0;
      o_sdram_chipselect   <= 1'b0;
      o_sdram_read_n       <= 1'b1;
      o_sdram_write_n      <= 1'b1;
      o_sdram_address      <= '0;
      o_sdram_writedata    <= '0;
      o_sdram_byteenable_n <= BE_NONE_N;
    end else begin
      o_done       <= '0;
      o_rd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant                <= pick_idx;
            rr_ptr               <= ptr_after_pick;
            cur_we               <= i_we[pick_idx];
            o_grant_id           <= 3'(pick_idx);
            o_busy               <= 1'b1;
            o_sdram_chipselect   <= 1'b1;
            o_sdram_read_n       <= i_we[pick_idx];
            o_sdram_write_n      <= ~i_we[pick_idx];
            o_sdram_address      <= addr_arr[pick_idx];
            o_sdram_writedata    <= {16'h0000, wdata_arr[pick_idx]};
            o_sdram_byteenable_n <= BE_LOW16_N;
            state                <= ISSUE;
          end
        end

        ISSUE: begin
          // Command stays registered and unchanged until the slave stops stalling.
          if (!i_sdram_waitrequest) begin
            o_sdram_chipselect <= 1'b0;
            o_sdram_read_n     <= 1'b1;
            o_sdram_write_n    <= 1'b1;
            if (cur_we) begin
              o_done[grant] <= 1'b1;
              state         <= DONE;
            end else begin
              rd_cnt <= '0;
              state  <= WAIT_RD;
            end
          end
        end

        WAIT_RD: begin
          if (i_sdram_readdatavalid) begin
            o_rdata       <= i_sdram_readdata[15:0];
            o_done[grant] <= 1'b1;
            state         <= DONE;
          end else if (rd_cnt_nxt == CNT_W'(RD_TIMEOUT)) begin
            o_rdata       <= '0;
            o_rd_timeout  <= 1'b1;
            o_done[grant] <= 1'b1;
            state         <= DONE;
          end else begin
            rd_cnt <= rd_cnt_nxt;
          end
        end

        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized clients and SDRAM slave,
// checked every cycle against a transaction-timeline reference model.
module tb_sdram_arbiter;

  localparam int NC    = 5;
  localparam int AW    = 23;
  localparam int RD_TO = 8;

  localparam int P_FREE = 0;
  localparam int P_CMD  = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     req = '0;
  logic [NC-1:0]     we = '0;
  logic [NC*AW-1:0]  addr = '0;
  logic [NC*16-1:0]  wdata = '0;
  logic [31:0]       rdata_in = '0;
  logic              rdv = 1'b0;
  logic              waitrequest = 1'b0;

  logic [15:0]       o_rdata;
  logic [NC-1:0]     o_done;
  logic [2:0]        o_grant_id;
  logic              o_busy;
  logic              o_rd_timeout;
  logic [AW-1:0]     o_sdram_address;
  logic [3:0]        o_sdram_byteenable_n;
  logic              o_sdram_chipselect;
  logic [31:0]       o_sdram_writedata;
  logic              o_sdram_read_n;
  logic              o_sdram_write_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: where the current transaction is on its timeline, and expected outputs.
  int            m_phase, m_ptr, m_owner, m_wait;
  logic          m_we;
  logic [NC-1:0] exp_done;
  logic [15:0]   exp_rdata;
  logic          exp_to, exp_busy, exp_cs, exp_rd_n, exp_wr_n;
  logic [2:0]    exp_gid;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata;

  // Slave behaviour state
  logic rd_pending = 1'b0;
  int   rd_delay   = 0;

  sdram_arbiter #(
    .N_CLIENTS  (NC),
    .ADDR_W     (AW),
    .RD_TIMEOUT (RD_TO)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_req                 (req),
    .i_we                  (we),
    .i_addr                (addr),
    .i_wdata               (wdata),
    .o_rdata               (o_rdata),
    .o_done                (o_done),
    .o_grant_id            (o_grant_id),
    .o_busy                (o_busy),
    .o_rd_timeout          (o_rd_timeout),
    .o_sdram_address       (o_sdram_address),
    .o_sdram_byteenable_n  (o_sdram_byteenable_n),
    .o_sdram_chipselect    (o_sdram_chipselect),
    .o_sdram_writedata     (o_sdram_writedata),
    .o_sdram_read_n        (o_sdram_read_n),
    .o_sdram_write_n       (o_sdram_write_n),
    .i_sdram_readdata      (rdata_in),
    .i_sdram_readdatavalid (rdv),
    .i_sdram_waitrequest   (waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NC-1:0] r, input int p);
    for (int i = 0; i < NC; i++) begin
      if (r[(p + i) % NC]) return (p + i) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_FREE; m_ptr = 0; m_owner = 0; m_wait = 0; m_we = 1'b0;
    exp_done = '0; exp_rdata = '0; exp_to = 1'b0; exp_busy = 1'b0;
    exp_cs = 1'b0; exp_rd_n = 1'b1; exp_wr_n = 1'b1; exp_gid = '0;
    exp_addr = '0; exp_wdata = '0;
  endtask

  // Advance the model across the coming clock edge using the inputs as currently driven.
  task automatic model_step();
    exp_done = '0;
    exp_to   = 1'b0;
    case (m_phase)
      P_FREE: if (req != '0) begin
        m_owner   = pick(req, m_ptr);
        m_ptr     = (m_owner + 1) % NC;
        m_we      = we[m_owner];
        exp_addr  = addr[m_owner*AW +: AW];
        exp_wdata = {16'h0000, wdata[m_owner*16 +: 16]};
        exp_cs    = 1'b1;
        exp_rd_n  = m_we;
        exp_wr_n  = !m_we;
        exp_busy  = 1'b1;
        exp_gid   = 3'(m_owner);
        m_phase   = P_CMD;
      end
      P_CMD: if (!waitrequest) begin
        exp_cs = 1'b0; exp_rd_n = 1'b1; exp_wr_n = 1'b1;
        if (m_we) begin
          exp_done[m_owner] = 1'b1;
          m_phase = P_DONE;
        end else begin
          m_wait  = 0;
          m_phase = P_WAIT;
        end
      end
      P_WAIT: begin
        if (rdv) begin
          exp_rdata = rdata_in[15:0];
          exp_done[m_owner] = 1'b1;
          m_phase = P_DONE;
        end else begin
          m_wait++;
          if (m_wait == RD_TO) begin
            exp_rdata = '0;
            exp_to = 1'b1;
            exp_done[m_owner] = 1'b1;
            m_phase = P_DONE;
          end
        end
      end
      default: begin
        exp_busy = 1'b0;
        m_phase  = P_FREE;
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("busy",       32'(o_busy),             32'(exp_busy));
    check("done",       32'(o_done),             32'(exp_done));
    check("rd_timeout", 32'(o_rd_timeout),       32'(exp_to));
    check("chipselect", 32'(o_sdram_chipselect), 32'(exp_cs));
    check("read_n",     32'(o_sdram_read_n),     32'(exp_rd_n));
    check("write_n",    32'(o_sdram_write_n),    32'(exp_wr_n));
    check("rdata",      32'(o_rdata),            32'(exp_rdata));
    if (exp_busy) check("grant_id", 32'(o_grant_id), 32'(exp_gid));
    if (exp_cs) begin
      check("address",      32'(o_sdram_address),      32'(exp_addr));
      check("writedata",    o_sdram_writedata,         exp_wdata);
      check("byteenable_n", 32'(o_sdram_byteenable_n), 32'(4'b1100));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state_busy"}, 32'(o_busy),               32'(0));
    check({tag, "_done"},       32'(o_done),               32'(0));
    check({tag, "_rdata"},      32'(o_rdata),              32'(0));
    check({tag, "_grant_id"},   32'(o_grant_id),           32'(0));
    check({tag, "_rd_timeout"}, 32'(o_rd_timeout),         32'(0));
    check({tag, "_cs"},         32'(o_sdram_chipselect),   32'(0));
    check({tag, "_read_n"},     32'(o_sdram_read_n),       32'(1));
    check({tag, "_write_n"},    32'(o_sdram_write_n),      32'(1));
    check({tag, "_address"},    32'(o_sdram_address),      32'(0));
    check({tag, "_writedata"},  o_sdram_writedata,         32'(0));
    check({tag, "_be_n"},       32'(o_sdram_byteenable_n), 32'(4'b1111));
  endtask

  task automatic new_params(input int k, input bit force_write);
    we[k] = force_write ? 1'b1 : 1'($urandom_range(0, 1));
    addr[k*AW +: AW] = AW'($urandom);
    wdata[k*16 +: 16] = 16'($urandom);
  endtask

  // mode 0: finish outstanding requests only; 1: random traffic; 2: every client always requesting writes.
  task automatic bench_cycle(input int mode);
    waitrequest = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    rdv = 1'b0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        rdv = 1'b1;
        rdata_in = $urandom;
        rd_pending = 1'b0;
      end else begin
        rd_delay--;
      end
    end else if (mode == 1 && $urandom_range(0, 15) == 0) begin
      rdv = 1'b1;
      rdata_in = $urandom;
    end
    if (o_sdram_chipselect && !o_sdram_read_n && !waitrequest) begin
      rd_pending = 1'b1;
      rd_delay = (mode == 1) ? $urandom_range(0, 9) : 0;
    end
    for (int k = 0; k < NC; k++) begin
      if (o_done[k]) begin
        req[k] = (mode == 2) || (mode == 1 && $urandom_range(0, 1) == 1);
        if (req[k]) new_params(k, mode == 2);
      end else if (!req[k] && (mode == 2 || (mode == 1 && $urandom_range(0, 7) == 0))) begin
        req[k] = 1'b1;
        new_params(k, mode == 2);
      end
    end
    cycle();
  endtask

  initial begin
    int seq;
    int idx;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write: client 1
    req = 5'b00010; we[1] = 1'b1;
    addr[1*AW +: AW] = 23'h000123;
    wdata[1*16 +: 16] = 16'hBEEF;
    cycle();
    check("wr_cmd_cs",      32'(o_sdram_chipselect),   32'(1));
    check("wr_cmd_write_n", 32'(o_sdram_write_n),      32'(0));
    check("wr_cmd_addr",    32'(o_sdram_address),      32'(23'h000123));
    check("wr_cmd_wdata",   o_sdram_writedata,         32'h0000BEEF);
    check("wr_cmd_be_n",    32'(o_sdram_byteenable_n), 32'(4'b1100));
    cycle();
    check("wr_done", 32'(o_done), 32'(5'b00010));
    req[1] = 1'b0;
    cycle();

    // Read with stall: client 4
    req[4] = 1'b1; we[4] = 1'b0;
    addr[4*AW +: AW] = 23'h7FFFFF;
    waitrequest = 1'b1;
    cycle();
    for (int s = 0; s < 3; s++) begin
      check("rd_stall_read_n", 32'(o_sdram_read_n),  32'(0));
      check("rd_stall_addr",   32'(o_sdram_address), 32'(23'h7FFFFF));
      cycle();
    end
    waitrequest = 1'b0;
    cycle();
    cycle();
    rdv = 1'b1; rdata_in = 32'hDEAD1234;
    cycle();
    check("rd_done",  32'(o_done),  32'(5'b10000));
    check("rd_rdata", 32'(o_rdata), 32'(16'h1234));
    rdv = 1'b0; req[4] = 1'b0;
    cycle();

    // Fairness: all clients request continuously; pointer sits at 0 after client 4
    req = '0;
    seq = 0;
    for (int c = 0; c < 40; c++) begin
      bench_cycle(2);
      if (o_done != '0) begin
        idx = -1;
        for (int k = 0; k < NC; k++) if (o_done[k]) idx = k;
        check("fair_order", 32'(idx), 32'(seq % NC));
        seq++;
      end
    end
    check("fair_count_ge10", 32'(seq >= 10), 32'(1));
    for (int c = 0; c < 30; c++) bench_cycle(0);

    // Read timeout: client 2
    req = 5'b00100; we[2] = 1'b0;
    addr[2*AW +: AW] = 23'h0ABCDE;
    cycle();
    cycle();
    for (int w = 0; w < RD_TO; w++) cycle();
    check("to_pulse", 32'(o_rd_timeout), 32'(1));
    check("to_done",  32'(o_done),       32'(5'b00100));
    check("to_rdata", 32'(o_rdata),      32'(0));
    req[2] = 1'b0;
    rdv = 1'b1; rdata_in = 32'h0000AAAA;
    cycle();
    cycle();
    check("late_rdv_done", 32'(o_done), 32'(0));
    rdv = 1'b0;
    cycle();

    // Reset during a read: client 3 in WAIT_RD
    req = 5'b01000; we[3] = 1'b0;
    addr[3*AW +: AW] = 23'h001111;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    req = '0;
    model_reset();
    rd_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdv = 1'b1; rdata_in = 32'h00005555;
    cycle();
    check("post_rst_rdv_done", 32'(o_done), 32'(0));
    rdv = 1'b0;
    req = 5'b10001; we[0] = 1'b1; we[4] = 1'b1;
    cycle();
    check("post_rst_grant", 32'(o_grant_id), 32'(0));
    for (int c = 0; c < 15; c++) bench_cycle(0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) bench_cycle(1);
    for (int c = 0; c < 80; c++) bench_cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
